// File: rtl/axi_stream_write_fifo.sv
// Buffered AXI4-Stream master: DEPTH words ({last,data}) queued; one-cycle push-to-tvalid latency via bypass.
// Backpressure: i_tready low holds the output word stable; o_ready drops at full and further pushes set sticky o_overflow.
module axi_stream_write_fifo #(
    parameter int BUS_WIDTH = 16,
    parameter int DEPTH     = 8
) (
    input  logic                   i_clk,
    input  logic                   i_aresetn,
    input  logic                   i_enable,
    input  logic [BUS_WIDTH-1:0]   i_data_to_transmit,
    input  logic                   i_last,
    output logic                   o_ready,
    output logic                   o_idle,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow,
    output logic                   o_tvalid,
    input  logic                   i_tready,
    output logic [BUS_WIDTH-1:0]   o_tdata,
    output logic                   o_tlast
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int RAM_N = DEPTH - 1;
    localparam int PW    = (RAM_N > 1) ? $clog2(RAM_N) : 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(RAM_N - 1);

    typedef struct packed {
        logic                 last;
        logic [BUS_WIDTH-1:0] dat;
    } word_t;

    word_t         mem [RAM_N];
    word_t         head_word;
    word_t         push_word;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] ram_cnt;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;
    logic          reg_free;
    logic          ram_empty;
    logic          load_ram;
    logic          load_byp;
    logic          ram_wr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign push      = i_enable & o_ready;
    assign pop       = o_tvalid & i_tready;
    assign reg_free  = ~o_tvalid | pop;
    // The output register is always filled first, so the RAM holds count minus that one word.
    assign ram_cnt   = o_count - {{(CW-1){1'b0}}, o_tvalid};
    assign ram_empty = (ram_cnt == '0);
    assign load_ram  = reg_free & ~ram_empty;
    assign load_byp  = reg_free & ram_empty & push;
    assign ram_wr    = push & ~load_byp;
    assign count_nxt = o_count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    assign head_word = mem[rd_ptr];
    assign push_word = '{last: i_last, dat: i_data_to_transmit};

    always_ff @(posedge i_clk) begin
        if (ram_wr) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_ready    <= 1'b1;
            o_idle     <= 1'b1;
            o_overflow <= 1'b0;
            o_tvalid   <= 1'b0;
            o_tdata    <= '0;
            o_tlast    <= 1'b0;
        end else begin
            if (ram_wr) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (load_ram) begin
                rd_ptr   <= next_ptr(rd_ptr);
                o_tdata  <= head_word.dat;
                o_tlast  <= head_word.last;
                o_tvalid <= 1'b1;
            end else if (load_byp) begin
                o_tdata  <= push_word.dat;
                o_tlast  <= push_word.last;
                o_tvalid <= 1'b1;
            end else if (pop) begin
                o_tvalid <= 1'b0;
            end
            if (i_enable && !o_ready) begin
                o_overflow <= 1'b1;
            end
            o_count <= count_nxt;
            o_ready <= (count_nxt < FULL_C);
            o_idle  <= (count_nxt == '0);
        end
    end

endmodule

// File: tb/tb_axi_stream_write_fifo.sv
// Randomised and directed bench for axi_stream_write_fifo against a queue-based reference model.
module tb_axi_stream_write_fifo;

    localparam int BW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [BW-1:0] din;
    logic          last;
    logic          ready;
    logic          idle;
    logic [3:0]    count;
    logic          ovf;
    logic          tvalid;
    logic          tready;
    logic [BW-1:0] tdata;
    logic          tlast;

    axi_stream_write_fifo #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .i_clk              (clk),
        .i_aresetn          (rst_n),
        .i_enable           (en),
        .i_data_to_transmit (din),
        .i_last             (last),
        .o_ready            (ready),
        .o_idle             (idle),
        .o_count            (count),
        .o_overflow         (ovf),
        .o_tvalid           (tvalid),
        .i_tready           (tready),
        .o_tdata            (tdata),
        .o_tlast            (tlast)
    );

    always #5 clk = ~clk;

    logic [BW:0] q[$];
    bit          m_ovf;
    int          n_chk;
    int          n_fail;
    int          cyc;
    int          beats;
    int          first_beat;
    int          last_beat;
    int          tlast_cnt;
    bit          last_beat_tlast;
    int          pushed;
    int          both;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_count"}, 32'(count), q.size());
        chk({tag, "_ready"}, 32'(ready), 32'(q.size() < DEPTH));
        chk({tag, "_idle"}, 32'(idle), 32'(q.size() == 0));
        chk({tag, "_tvalid"}, 32'(tvalid), 32'(q.size() > 0));
        chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
        if (q.size() > 0) begin
            chk({tag, "_tdata"}, 32'(tdata), 32'(q[0][BW-1:0]));
            chk({tag, "_tlast"}, 32'(tlast), 32'(q[0][BW]));
        end
    endtask

    // One clock: note any handshake, advance the model by the rules, then compare after the edge.
    task automatic step(input string tag);
        bit push_ok;
        bit pop_ok;
        if (tvalid && tready) begin
            if (beats == 0) first_beat = cyc;
            beats++;
            last_beat       = cyc;
            last_beat_tlast = tlast;
            if (tlast) tlast_cnt++;
        end
        @(posedge clk);
        cyc++;
        push_ok = en && (q.size() < DEPTH);
        pop_ok  = (q.size() > 0) && tready;
        if (en && !push_ok) m_ovf = 1'b1;
        if (push_ok && pop_ok) both++;
        if (pop_ok) void'(q.pop_front());
        if (push_ok) begin
            q.push_back({last, din});
            pushed++;
        end
        #1;
        check_all(tag);
    endtask

    task automatic clear_beats();
        beats = 0; first_beat = 0; last_beat = 0; tlast_cnt = 0; last_beat_tlast = 0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; m_ovf = 0; pushed = 0; both = 0;
        clear_beats();
        rst_n = 1'b1; en = 1'b0; din = '0; last = 1'b0; tready = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        check_all("rst");
        chk("rst_tdata", 32'(tdata), 0);
        chk("rst_tlast", 32'(tlast), 0);
        rst_n = 1'b1;

        // T1: async reset with three words held
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; din = BW'(16'h0100 + i); last = (i == 2);
            step("t1_fill");
        end
        en = 1'b0;
        chk("t1_held", 32'(count), 3);
        #3 rst_n = 1'b0;
        q.delete();
        #1;
        check_all("t1_async");
        chk("t1_tdata", 32'(tdata), 0);
        chk("t1_tlast", 32'(tlast), 0);
        @(posedge clk);
        #4 rst_n = 1'b1;
        step("t1_post");

        // T2: single word, one-cycle latency
        en = 1'b1; din = 16'hA5A5; last = 1'b1; tready = 1'b1;
        step("t2_push");
        chk("t2_tvalid", 32'(tvalid), 1);
        chk("t2_tdata", 32'(tdata), 32'hA5A5);
        chk("t2_tlast", 32'(tlast), 1);
        en = 1'b0; last = 1'b0;
        step("t2_pop");
        chk("t2_idle", 32'(idle), 1);

        // T3: fill under backpressure, overflow, drain in order
        tready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            en = 1'b1; din = BW'(i);
            step("t3_fill");
        end
        chk("t3_count", 32'(count), 8);
        chk("t3_ready", 32'(ready), 0);
        chk("t3_tdata", 32'(tdata), 1);
        din = 16'h0009;
        step("t3_over");
        chk("t3_ovf", 32'(ovf), 1);
        chk("t3_count_full", 32'(count), 8);
        en = 1'b0; tready = 1'b1;
        for (int i = 0; i < 8; i++) step("t3_drain");
        chk("t3_empty", 32'(idle), 1);

        // T4: continuous streaming at full rate
        clear_beats();
        for (int i = 1; i <= 32; i++) begin
            en = 1'b1; din = BW'(16'h4000 + i); last = (i == 32);
            step("t4_stream");
            chk("t4_count_le1", 32'(count <= 4'd1), 1);
        end
        en = 1'b0; last = 1'b0;
        for (int k = 0; k < 10 && q.size() > 0; k++) step("t4_drain");
        step("t4_tail");
        chk("t4_beats", beats, 32);
        chk("t4_consecutive", last_beat - first_beat, 31);
        chk("t4_tlast_cnt", tlast_cnt, 1);
        chk("t4_tlast_final", 32'(last_beat_tlast), 1);
        chk("t4_empty", 32'(count), 0);

        // T5: random enable/ready over 1000 accepted words
        pushed = 0; both = 0;
        for (int k = 0; k < 8000 && pushed < 1000; k++) begin
            en = 1'($urandom % 2); tready = 1'($urandom % 2);
            din = BW'($urandom); last = 1'($urandom % 2);
            step("t5_rand");
        end
        chk("t5_pushed", pushed, 1000);
        en = 1'b0; tready = 1'b1; last = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++) step("t5_drain");
        chk("t5_empty", 32'(count), 0);

        // T6: output stable while the sink stalls
        tready = 1'b0; en = 1'b1; din = 16'h5A3C; last = 1'b1;
        step("t6_push");
        en = 1'b0; last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("t6_stall");
            chk("t6_tvalid", 32'(tvalid), 1);
            chk("t6_tdata", 32'(tdata), 32'h5A3C);
            chk("t6_tlast", 32'(tlast), 1);
        end
        tready = 1'b1;
        step("t6_release");
        chk("t6_idle", 32'(idle), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
